cu_datapath_sequencer: RTL and testbench

Microsequencer for the bus/register-file/ALU/shifter datapath. Accepts 16-bit micro-instructions over a valid/ready handshake into a 2-entry buffer. Executes each instruction in a fixed 4-state sequence, driving bus A/B mux selects, ALU select, shifter select and the write decoder select. Sits beside the datapath inside the system wrapper and replaces hard-wired select constants.

---
 rtl/cu_datapath_sequencer.sv | 147 ++++++++++++++
 tb/tb_cu_datapath_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cu_datapath_sequencer.sv
// Microsequencer for the bus/register-file/ALU/shifter datapath: buffers 16-bit
// micro-instructions in a 2-entry FIFO and steps each through DECODE/EXECUTE/SHIFT/WRITE.
module cu_datapath_sequencer #(
  parameter int DATAWIDTH_MUX_SELECTION        = 3,
  parameter int DATAWIDTH_ALU_SELECTION        = 4,
  parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
  parameter int DATAWIDTH_DECODER_SELECTION    = 3,
  parameter logic [DATAWIDTH_ALU_SELECTION-1:0]        ALU_IDLE     = 4'b0000,
  parameter logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SHIFT_IDLE   = 2'b00,
  parameter logic [DATAWIDTH_DECODER_SELECTION-1:0]    DECODER_IDLE = 3'b111,
  parameter int DATAWIDTH_COUNT                = 8
) (
  input  logic                                      CU_SEQ_CLOCK_50,
  input  logic                                      CU_SEQ_Reset_InHigh,
  input  logic [15:0]                               CU_SEQ_Instr_In,
  input  logic                                      CU_SEQ_InstrValid_In,
  output logic                                      CU_SEQ_InstrReady_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        CU_SEQ_MuxASel_Out,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]        CU_SEQ_MuxBSel_Out,
  output logic [DATAWIDTH_ALU_SELECTION-1:0]        CU_SEQ_ALUSel_Out,
  output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] CU_SEQ_ShiftSel_Out,
  output logic [DATAWIDTH_DECODER_SELECTION-1:0]    CU_SEQ_DecoderSel_Out,
  output logic                                      CU_SEQ_Busy_Out,
  output logic                                      CU_SEQ_Done_Out,
  output logic [DATAWIDTH_COUNT-1:0]                CU_SEQ_Retired_Out
);

  typedef enum logic [2:0] {IDLE, DECODE, EXECUTE, SHIFT, WRITE} state_t;

  state_t      state, stateNext;
  logic [15:0] fifoMem [2];
  logic        wrPtr, rdPtr;
  logic [1:0]  count, countNext;
  logic        fifoSeen;
  logic        push, pop;
  logic [15:0] instr, instrNext;

  logic [DATAWIDTH_MUX_SELECTION-1:0]        muxANext, muxBNext;
  logic [DATAWIDTH_ALU_SELECTION-1:0]        aluNext;
  logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] shiftNext;
  logic [DATAWIDTH_DECODER_SELECTION-1:0]    decoderNext;
  logic                                      doneNext;
  logic [DATAWIDTH_COUNT-1:0]                retiredNext;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    push      = CU_SEQ_InstrValid_In && CU_SEQ_InstrReady_Out && !CU_SEQ_Reset_InHigh;
    pop       = 1'b0;
    stateNext = state;
    instrNext = instr;

    unique case (state)
      // IDLE waits one cycle after an entry lands so the head is seen through fifoSeen.
      IDLE: begin
        if (fifoSeen && count != 2'd0) begin
          pop       = 1'b1;
          instrNext = fifoMem[rdPtr];
          stateNext = DECODE;
        end
      end
      DECODE:  stateNext = EXECUTE;
      EXECUTE: stateNext = SHIFT;
      SHIFT:   stateNext = WRITE;
      WRITE: begin
        if (count != 2'd0) begin
          pop       = 1'b1;
          instrNext = fifoMem[rdPtr];
          stateNext = DECODE;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase

    unique case ({push, pop})
      2'b10:   countNext = count + 2'd1;
      2'b01:   countNext = count - 2'd1;
      default: countNext = count;
    endcase

    // Outputs are computed for the state being entered so the registers line up with it.
    muxANext    = '0;
    muxBNext    = '0;
    aluNext     = ALU_IDLE;
    shiftNext   = SHIFT_IDLE;
    decoderNext = DECODER_IDLE;
    doneNext    = 1'b0;
    if (stateNext != IDLE) begin
      muxANext = instrNext[15:13];
      muxBNext = instrNext[12:10];
    end
    case (stateNext)
      EXECUTE: aluNext = instrNext[9:6];
      SHIFT:   shiftNext = instrNext[5:4];
      WRITE: begin
        doneNext = 1'b1;
        if (instrNext[0]) decoderNext = instrNext[3:1];
      end
      default: ;
    endcase
    retiredNext = CU_SEQ_Retired_Out + DATAWIDTH_COUNT'(doneNext);
  end

  // NOTE: storage array has no reset; count/pointers define which entries are meaningful.
  always_ff @(posedge CU_SEQ_CLOCK_50) begin
    if (push) fifoMem[wrPtr] <= CU_SEQ_Instr_In;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CU_SEQ_CLOCK_50) begin
    if (CU_SEQ_Reset_InHigh) begin
      state                 <= IDLE;
      instr                 <= '0;
      wrPtr                 <= 1'b0;
      rdPtr                 <= 1'b0;
      count                 <= 2'd0;
      fifoSeen              <= 1'b0;
      CU_SEQ_InstrReady_Out <= 1'b1;
      CU_SEQ_MuxASel_Out    <= '0;
      CU_SEQ_MuxBSel_Out    <= '0;
      CU_SEQ_ALUSel_Out     <= ALU_IDLE;
      CU_SEQ_ShiftSel_Out   <= SHIFT_IDLE;
      CU_SEQ_DecoderSel_Out <= DECODER_IDLE;
      CU_SEQ_Busy_Out       <= 1'b0;
      CU_SEQ_Done_Out       <= 1'b0;
      CU_SEQ_Retired_Out    <= '0;
    end else begin
      state                 <= stateNext;
      instr                 <= instrNext;
      if (push) wrPtr       <= ~wrPtr;
      if (pop)  rdPtr       <= ~rdPtr;
      count                 <= countNext;
      fifoSeen              <= (count != 2'd0);
      CU_SEQ_InstrReady_Out <= (countNext < 2'd2);
      CU_SEQ_MuxASel_Out    <= muxANext;
      CU_SEQ_MuxBSel_Out    <= muxBNext;
      CU_SEQ_ALUSel_Out     <= aluNext;
      CU_SEQ_ShiftSel_Out   <= shiftNext;
      CU_SEQ_DecoderSel_Out <= decoderNext;
      CU_SEQ_Busy_Out       <= (stateNext != IDLE);
      CU_SEQ_Done_Out       <= doneNext;
      CU_SEQ_Retired_Out    <= retiredNext;
    end
  end

endmodule

// File: tb/tb_cu_datapath_sequencer.sv
// Directed bench for cu_datapath_sequencer: each step drives inputs just after an edge
// and compares registered outputs against hand-derived values with immediate assertions.
module tb_cu_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instrIn;
  logic        validIn;
  logic        ready;
  logic [2:0]  muxA, muxB;
  logic [3:0]  alu;
  logic [1:0]  shift;
  logic [2:0]  dec;
  logic        busy, done;
  logic [7:0]  retired;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cu_datapath_sequencer dut (
    .CU_SEQ_CLOCK_50       (clk),
    .CU_SEQ_Reset_InHigh   (rst),
    .CU_SEQ_Instr_In       (instrIn),
    .CU_SEQ_InstrValid_In  (validIn),
    .CU_SEQ_InstrReady_Out (ready),
    .CU_SEQ_MuxASel_Out    (muxA),
    .CU_SEQ_MuxBSel_Out    (muxB),
    .CU_SEQ_ALUSel_Out     (alu),
    .CU_SEQ_ShiftSel_Out   (shift),
    .CU_SEQ_DecoderSel_Out (dec),
    .CU_SEQ_Busy_Out       (busy),
    .CU_SEQ_Done_Out       (done),
    .CU_SEQ_Retired_Out    (retired)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Packs busy/done/mux/alu/shift/dec into one word: {busy,done,muxA,muxB,alu,shift,dec}.
  function automatic logic [31:0] outs(input logic b, input logic d, input logic [2:0] ma,
                                       input logic [2:0] mb, input logic [3:0] a,
                                       input logic [1:0] s, input logic [2:0] de);
    return {15'd0, b, d, ma, mb, a, s, de};
  endfunction

  function automatic logic [31:0] obs();
    return {15'd0, busy, done, muxA, muxB, alu, shift, dec};
  endfunction

  localparam logic [15:0] I_SINGLE = 16'h28D5; // 001_010_0011_01_010_1
  localparam logic [15:0] I_NOWE   = 16'h7162; // 011_100_0101_10_001_0
  localparam logic [15:0] I_A      = 16'hB877; // 101_110_0001_11_011_1
  localparam logic [15:0] I_B      = 16'hC7C9; // 110_001_1111_00_100_1
  localparam logic [15:0] I_C      = 16'h4DAB; // 010_011_0110_10_101_1

  initial begin
    int doneCount;
    int cycles;

    // Reset held two cycles with Valid high: nothing may be recorded.
    rst = 1'b1; validIn = 1'b1; instrIn = I_SINGLE;
    tick(); tick();
    check("rst_ready", ready, 1);
    check("rst_outs", obs(), outs(0, 0, 0, 0, 4'h0, 2'd0, 3'd7));
    check("rst_retired", retired, 0);
    rst = 1'b0; validIn = 1'b0;
    tick(); tick(); tick();
    check("rst_no_push", busy, 0);

    // Single instruction from IDLE.
    validIn = 1'b1; instrIn = I_SINGLE;
    tick();                               // push edge
    validIn = 1'b0;
    check("single_push_ready", ready, 1);
    tick();
    check("single_idle_wait", obs(), outs(0, 0, 0, 0, 4'h0, 2'd0, 3'd7));
    tick();
    check("single_decode", obs(), outs(1, 0, 1, 2, 4'h0, 2'd0, 3'd7));
    tick();
    check("single_execute", obs(), outs(1, 0, 1, 2, 4'h3, 2'd0, 3'd7));
    tick();
    check("single_shift", obs(), outs(1, 0, 1, 2, 4'h0, 2'd1, 3'd7));
    tick();
    check("single_write", obs(), outs(1, 1, 1, 2, 4'h0, 2'd0, 3'd2));
    check("single_retired", retired, 1);
    tick();
    check("single_idle", obs(), outs(0, 0, 0, 0, 4'h0, 2'd0, 3'd7));
    check("single_retired_hold", retired, 1);

    // Write-enable clear: no strobe, Done and count still advance.
    validIn = 1'b1; instrIn = I_NOWE;
    tick();
    validIn = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    check("nowe_write", obs(), outs(1, 1, 3, 4, 4'h0, 2'd0, 3'd7));
    check("nowe_retired", retired, 2);
    tick();
    check("nowe_idle", busy, 0);

    // Back-to-back with Valid held high.
    validIn = 1'b1; instrIn = I_A;
    tick();                               // A accepted
    check("b2b_ready_1", ready, 1);
    instrIn = I_B;
    tick();                               // B accepted, buffer full
    check("b2b_ready_full", ready, 0);
    check("b2b_still_idle", busy, 0);
    instrIn = I_C;
    tick();                               // A pops, C waits
    check("b2b_a_decode", obs(), outs(1, 0, 5, 6, 4'h0, 2'd0, 3'd7));
    check("b2b_ready_reopen", ready, 1);
    tick();                               // C accepted
    validIn = 1'b0;
    check("b2b_ready_full2", ready, 0);
    check("b2b_a_execute", alu, 4'h1);
    tick();
    check("b2b_a_shift", shift, 2'd3);
    tick();
    check("b2b_a_write", obs(), outs(1, 1, 5, 6, 4'h0, 2'd0, 3'd3));
    check("b2b_a_retired", retired, 3);
    tick();
    check("b2b_b_decode", obs(), outs(1, 0, 6, 1, 4'h0, 2'd0, 3'd7));
    tick();
    check("b2b_b_execute", alu, 4'hF);
    tick();
    check("b2b_b_shift", obs(), outs(1, 0, 6, 1, 4'h0, 2'd0, 3'd7));
    tick();
    check("b2b_b_write", obs(), outs(1, 1, 6, 1, 4'h0, 2'd0, 3'd4));
    check("b2b_b_retired", retired, 4);
    tick();
    check("b2b_c_decode", obs(), outs(1, 0, 2, 3, 4'h0, 2'd0, 3'd7));
    tick(); tick(); tick();
    check("b2b_c_write", obs(), outs(1, 1, 2, 3, 4'h0, 2'd0, 3'd5));
    check("b2b_c_retired", retired, 5);
    tick();
    check("b2b_idle", obs(), outs(0, 0, 0, 0, 4'h0, 2'd0, 3'd7));

    // Reset during SHIFT of the first of two buffered instructions.
    validIn = 1'b1; instrIn = I_A;
    tick();
    instrIn = I_B;
    tick();
    validIn = 1'b0;
    tick(); tick(); tick();
    check("abort_in_shift", obs(), outs(1, 0, 5, 6, 4'h0, 2'd3, 3'd7));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_outs", obs(), outs(0, 0, 0, 0, 4'h0, 2'd0, 3'd7));
    check("abort_retired", retired, 0);
    check("abort_ready", ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort_quiet", {busy, done, dec}, {1'b0, 1'b0, 3'd7});
    end
    check("abort_retired_hold", retired, 0);

    // Counter wrap: 256 retirements with Valid held high.
    validIn = 1'b1; instrIn = I_SINGLE;
    doneCount = 0;
    cycles = 0;
    while (doneCount < 256 && cycles < 2000) begin
      tick();
      cycles++;
      if (done) begin
        doneCount++;
        if (doneCount == 255) check("wrap_255", retired, 8'd255);
        if (doneCount == 256) check("wrap_256", retired, 8'd0);
      end
    end
    validIn = 1'b0;
    check("wrap_done_count", doneCount, 256);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
